rx_fifo_pop_ctrl: RTL

//  Read-side controller for the PCS RX clock-crossing FIFO; runs entirely in the read clock domain.

---
 rtl/rx_fifo_pop_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rx_fifo_pop_ctrl.sv
// rx_fifo_pop_ctrl: read-side controller for the PCS RX clock-crossing FIFO.
// It pops words from the FIFO into a 2-entry skid buffer and presents them
// downstream as a valid/ready stream. Words around FIFO forced-drain (dissync)
// events are dropped, and those events are counted. The first word delivered
// after a loss is marked with out_discont.
module rx_fifo_pop_ctrl #(
  parameter int WR_WIDTH     = 48,
  parameter int CNT_WIDTH    = 16,
  parameter int RESYNC_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_enable,
  input  logic                 fifo_canpop,
  output logic                 fifo_pop_rd,
  input  logic [WR_WIDTH-1:0]  fifo_data_rd,
  input  logic                 fifo_data_valid,
  input  logic                 fifo_dissync,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [WR_WIDTH-1:0]  out_data,
  output logic                 out_discont,
  input  logic                 clear_cnt,
  output logic [CNT_WIDTH-1:0] loss_cnt,
  output logic [1:0]           fsm_state
);

  localparam int QW = $clog2(RESYNC_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOSS = 2'd2
  } state_t;

  typedef struct packed {
    logic                discont;
    logic [WR_WIDTH-1:0] data;
  } entry_t;

  state_t           state_q, state_d;
  logic [QW-1:0]    quiet_q, quiet_d;
  logic             pend_q, pend_d;   // next pushed word gets out_discont
  logic [1:0]       occ_q;
  entry_t [1:0]     skid_q;           // [0] is the head
  entry_t           push_e;
  logic             accept, push, xfer, inc;

  // Pop depends only on registered occupancy, never on out_ready.
  assign fifo_pop_rd = in_enable & fifo_canpop & ~occ_q[1] & ~reset;
  assign accept      = fifo_pop_rd & fifo_data_valid;
  assign out_valid   = (occ_q != 2'd0);
  assign xfer        = out_valid & out_ready;
  assign out_data    = skid_q[0].data;
  assign out_discont = skid_q[0].discont;
  assign fsm_state   = state_q;
  assign inc         = in_enable & fifo_dissync;

  // FSM state, quiet counter and pending-discontinuity register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      quiet_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      quiet_q <= quiet_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic and the push decision; everything holds while in_enable is low.
  always_comb begin
    state_d = state_q;
    quiet_d = quiet_q;
    pend_d  = pend_q;
    push    = 1'b0;
    push_e  = {1'b0, fifo_data_rd};
    if (in_enable) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            push    = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          // A word accepted alongside dissync is dropped.
          if (fifo_dissync) begin
            state_d = LOSS;
            quiet_d = '0;
          end else if (accept) begin
            push           = 1'b1;
            push_e.discont = pend_q;
            pend_d         = 1'b0;
          end
        end
        LOSS: begin
          // Accepted words are still popped (FIFO keeps draining) but dropped.
          if (fifo_dissync) begin
            quiet_d = '0;
          end else if (quiet_q == QW'(RESYNC_WORDS - 1)) begin
            state_d = RUN;
            quiet_d = '0;
            pend_d  = 1'b1;
          end else begin
            quiet_d = quiet_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Skid buffer: in-order 2-entry storage with shift-on-transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q  <= 2'd0;
      skid_q <= '0;
    end else begin
      case ({push, xfer})
        2'b10: begin
          if (occ_q == 2'd0) skid_q[0] <= push_e;
          else               skid_q[1] <= push_e;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          skid_q[0] <= skid_q[1];
          occ_q     <= occ_q - 2'd1;
        end
        2'b11: begin
          // Push needs occ<2, so only occ 1 reaches here; occupancy is unchanged.
          skid_q[0] <= push_e;
        end
        default: ;
      endcase
    end
  end

  // Saturating loss-event counter; clear wins but still counts a same-cycle event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loss_cnt <= '0;
    end else if (clear_cnt) begin
      loss_cnt <= {{(CNT_WIDTH-1){1'b0}}, inc};
    end else if (inc && !(&loss_cnt)) begin
      loss_cnt <= loss_cnt + 1'b1;
    end
  end

endmodule
